spi_frame_rx: RTL and testbench

- clk-domain SPI slave front end for the ALU datapath; replaces the SCLK-clocked receiver.
- Oversamples SCLK/MOSI/SS with clk and assembles one FRAME_BITS operand/opcode frame per SS-low window: bits[9:6]=a, bits[5:2]=b, bits[1:0]=Sel.
- Presents the frame with a one-cycle valid strobe.
- Shifts a TX_BITS status word (ALU result + flags) back on MISO during the same transaction.

---
 rtl/spi_frame_rx.sv | 115 +++++++++++
 tb/tb_spi_frame_rx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: clk-domain SPI mode-0 slave that captures one operand/opcode frame per SS-low window and shifts a status word back on MISO.
// Optional even-parity frame checking is enabled by defining SPI_PARITY_EN.
module spi_frame_rx #(
    parameter int FRAME_BITS  = 10,
    parameter int TX_BITS     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  SS,
    output logic                  MISO,
    input  logic [TX_BITS-1:0]    tx_data,
    output logic [FRAME_BITS-1:0] frame_out,
    output logic                  frame_valid,
    output logic                  frame_err
);
`ifdef SPI_PARITY_EN
    localparam int RX_BITS = FRAME_BITS + 1;
`else
    localparam int RX_BITS = FRAME_BITS;
`endif
    localparam int MAX_CNT = RX_BITS + 1;
    localparam int CW = $clog2(MAX_CNT + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic sclk_s, mosi_s, ss_s, sclk_d, ss_d, armed;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall, good;
    logic [CW-1:0] cnt;
    logic [RX_BITS-1:0] rx_sh;
    logic [TX_BITS-1:0] tx_sh;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign MISO = (state == ACTIVE) & tx_sh[TX_BITS-1];

    // armed requires SS to be seen high after reset, so a select held low across reset is not captured
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            armed     <= armed | ss_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE && ss_fall && armed) state_n = ACTIVE;
        if (state == ACTIVE && ss_rise)         state_n = IDLE;
    end

`ifdef SPI_PARITY_EN
    assign good = (cnt == CW'(RX_BITS)) && !(^rx_sh);
`else
    assign good = (cnt == CW'(RX_BITS));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (state == IDLE && ss_fall && armed) begin
                cnt   <= '0;
                rx_sh <= '0;
                tx_sh <= tx_data;
            end else if (state == ACTIVE) begin
                if (ss_rise) begin
                    if (good) begin
                        frame_out   <= rx_sh[RX_BITS-1 -: FRAME_BITS];
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_sh <= {rx_sh[RX_BITS-2:0], mosi_s};
                        cnt   <= (cnt == CW'(MAX_CNT)) ? cnt : cnt + 1'b1;
                    end
                    if (sclk_fall) tx_sh <= tx_sh << 1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: directed scoreboard bench for spi_frame_rx; expected frame events are queued at stimulus time and popped by a pulse monitor.
module tb_spi_frame_rx;
`ifdef SPI_PARITY_EN
    localparam int LEN = 11;
`else
    localparam int LEN = 10;
`endif
    typedef struct packed {
        logic       err;
        logic [9:0] frame;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, SCLK = 1'b0, MOSI = 1'b0, SS = 1'b1, MISO;
    logic [7:0] tx_data = 8'h00;
    logic [9:0] frame_out;
    logic frame_valid, frame_err;
    exp_t q[$];
    int n_checks = 0, n_fail = 0, nv = 0, ne = 0;
    logic [15:0] cap;

    spi_frame_rx dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
        .tx_data(tx_data), .frame_out(frame_out), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each pulse consumes one scoreboard entry; a pulse with nothing queued is a failure.
    always @(negedge clk) begin
        if (frame_valid === 1'b1 || frame_err === 1'b1) begin
            exp_t e;
            check("both_pulses", {31'd0, frame_valid & frame_err}, 32'd0);
            if (frame_valid === 1'b1) nv++;
            if (frame_err === 1'b1) ne++;
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
                check("frame_out", {22'd0, frame_out}, {22'd0, e.frame});
            end
        end
    end

    function automatic logic [15:0] good_bits(input logic [9:0] d);
`ifdef SPI_PARITY_EN
        return {5'd0, d, ^d};
`else
        return {6'd0, d};
`endif
    endfunction

    // Master side: MOSI set in the low phase, MISO sampled at each SCLK rise.
    task automatic clock_bits(input logic [15:0] bits, input int n, output logic [15:0] c);
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = bits[i];
            wait_clk(5);
            SCLK = 1'b1;
            c = {c[14:0], MISO};
            if (i == n - 1) tx_data = ~tx_data;
            wait_clk(5);
            SCLK = 1'b0;
        end
    endtask

    task automatic send(input logic [15:0] bits, input int n, output logic [15:0] c);
        SS = 1'b0;
        wait_clk(5);
        clock_bits(bits, n, c);
        wait_clk(5);
        SS = 1'b1;
        wait_clk(20);
    endtask

    initial begin
        wait_clk(5);
        check("rst_frame_out", {22'd0, frame_out}, 32'd0);
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_miso", {31'd0, MISO}, 32'd0);
        rst = 1'b0;
        wait_clk(10);

        tx_data = 8'hA5;
        q.push_back('{1'b0, 10'h28D});
        send(good_bits(10'h28D), LEN, cap);
        check("t1_pending", q.size(), 32'd0);
        check("t1_nv", nv, 32'd1);
        check("t1_ne", ne, 32'd0);
        check("t1_miso", {22'd0, cap[LEN-1 -: 10]}, 32'b1010010100);
        check("t1_frame", {22'd0, frame_out}, 32'h28D);

        q.push_back('{1'b1, 10'h28D});
        send(16'hFFFF, LEN - 1, cap);
        q.push_back('{1'b1, 10'h28D});
        send(16'hFFFF, LEN + 1, cap);
        check("t2_pending", q.size(), 32'd0);
        check("t2_nv", nv, 32'd1);
        check("t2_ne", ne, 32'd2);
        check("t2_frame", {22'd0, frame_out}, 32'h28D);

        SS = 1'b0;
        wait_clk(5);
        clock_bits(16'h001F, 5, cap);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(10);
        SS = 1'b1;
        wait_clk(20);
        check("t3_nv", nv, 32'd1);
        check("t3_ne", ne, 32'd2);
        check("t3_frame_cleared", {22'd0, frame_out}, 32'd0);
        q.push_back('{1'b0, 10'h3FF});
        send(good_bits(10'h3FF), LEN, cap);
        check("t3_pending", q.size(), 32'd0);
        check("t3_nv2", nv, 32'd2);
        check("t3_frame", {22'd0, frame_out}, 32'h3FF);

        q.push_back('{1'b1, 10'h3FF});
        SS = 1'b0;
        wait_clk(20);
        SS = 1'b1;
        wait_clk(20);
        check("t4_pending", q.size(), 32'd0);
        check("t4_ne", ne, 32'd3);
        check("t4_miso_idle", {31'd0, MISO}, 32'd0);

`ifdef SPI_PARITY_EN
        q.push_back('{1'b0, 10'h28D});
        send({5'd0, 10'h28D, 1'b1}, 11, cap);
        check("par_ok_nv", nv, 32'd3);
        check("par_ok_frame", {22'd0, frame_out}, 32'h28D);
        q.push_back('{1'b1, 10'h28D});
        send({5'd0, 10'h28D, 1'b0}, 11, cap);
        check("par_bad_ne", ne, 32'd4);
        check("par_bad_frame", {22'd0, frame_out}, 32'h28D);
`endif
        check("final_pending", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
